systolic_mm_engine: RTL and testbench

Output-stationary SIZE×SIZE signed matrix-multiply engine computing C = A·B with one valid/ready transaction per matrix pair. The block captures both operand matrices, internally skews A rows and B columns through a grid of multiply-accumulate PEs, and presents the full C matrix on a held output. It supersedes the combinational-chain array: it adds real systolic data movement, a parametrised accumulator width, handshakes, and optional saturation.

---
 rtl/systolic_mm_pkg.sv | 28 ++
 rtl/systolic_mm_pe.sv | 68 ++++++
 rtl/systolic_mm_engine.sv | 138 +++++++++++++
 tb/tb_systolic_mm_engine.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_mm_pkg.sv
// systolic_mm_pkg: shared FSM encoding, counter sizing and saturation limits.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package systolic_mm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Width of the skew counter t, which runs 0 .. 3*size-3.
  function automatic int cnt_width(input int size);
    return $clog2(3 * size - 2);
  endfunction

  // Saturation bound for a signed accumulator of the given width:
  // most negative value when neg is set, most positive otherwise.
  function automatic logic signed [63:0] sat_limit(input logic neg, input int width);
    logic signed [63:0] one;
    one = 64'sd1;
    if (neg) begin
      return -(one <<< (width - 1));
    end
    return (one <<< (width - 1)) - one;
  endfunction

endpackage

// File: rtl/systolic_mm_pe.sv
// systolic_mm_pe: one output-stationary MAC cell; forwards a right and b down.
// Latency: 1 cycle per hop for a/b forwarding, accumulator updates on the enable edge.
// Backpressure: none; the cell advances every cycle and holds acc while en is low.
// SYSTOLIC_MM_SAT_EN defined: saturating accumulate with sat flag; otherwise wraps.
module systolic_mm_pe
  import systolic_mm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  acc,
  output logic                         sat
);

  localparam int PW = 2 * DATA_WIDTH;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  logic signed [PW-1:0] prod;
  acc_t                 prod_ext;
  acc_t                 acc_nxt;

  // Full-precision signed product, sign-extended to the accumulator width.
  assign prod     = PW'(a_in) * PW'(b_in);
  assign prod_ext = acc_t'(prod);

`ifdef SYSTOLIC_MM_SAT_EN
  logic signed [ACC_WIDTH:0] sum_ext;
  logic                      clamp;

  // Add with one guard bit; a guard/sign disagreement means the sum left the range.
  always_comb begin
    sum_ext = {acc[ACC_WIDTH-1], acc} + {prod_ext[ACC_WIDTH-1], prod_ext};
    clamp   = sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1];
    acc_nxt = clamp ? acc_t'(sat_limit(sum_ext[ACC_WIDTH], ACC_WIDTH))
                    : sum_ext[ACC_WIDTH-1:0];
  end

  assign sat = en && clamp;
`else
  assign acc_nxt = acc + prod_ext;
  assign sat     = 1'b0;
`endif

  // Forwarding registers move every cycle; accumulator only advances while enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (en) begin
        acc <= acc_nxt;
      end
    end
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: output-stationary SIZE x SIZE signed matrix multiply C = A*B.
// Latency: accept edge to out_valid is 3*SIZE-1 cycles; one transaction per 3*SIZE cycles.
// Backpressure: result and ovf held in DONE until out_ready; in_ready low while busy.
// SYSTOLIC_MM_SAT_EN defined: accumulators saturate and ovf reports it; otherwise wrap, ovf 0.
module systolic_mm_engine
  import systolic_mm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 4,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*SIZE*SIZE-1:0]   a_in,
  input  logic [DATA_WIDTH*SIZE*SIZE-1:0]   b_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_WIDTH*SIZE*SIZE-1:0]    result,
  output logic                              ovf,
  output logic                              busy
);

  localparam int                OPW    = DATA_WIDTH * SIZE * SIZE;
  localparam int                CNT_W  = cnt_width(SIZE);
  localparam logic [CNT_W-1:0]  T_LAST = CNT_W'(3 * SIZE - 3);

  state_t           state;
  logic [CNT_W-1:0] t;
  logic [OPW-1:0]   a_reg;
  logic [OPW-1:0]   b_reg;
  logic             clr;
  logic             en;

  logic signed [DATA_WIDTH-1:0] a_inj [SIZE];
  logic signed [DATA_WIDTH-1:0] b_inj [SIZE];
  logic signed [DATA_WIDTH-1:0] a_fwd [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] b_fwd [SIZE][SIZE];
  logic [SIZE*SIZE-1:0]         sat_vec;

  assign clr       = (state == IDLE) && in_valid;
  assign en        = (state == COMPUTE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Skew injection: row r of A and column r of B enter r cycles late, zeros outside.
  always_comb begin
    for (int r = 0; r < SIZE; r++) begin
      a_inj[r] = '0;
      b_inj[r] = '0;
    end
    if (en) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int k = 0; k < SIZE; k++) begin
          if (int'(t) == r + k) begin
            a_inj[r] = a_reg[(r*SIZE+k)*DATA_WIDTH +: DATA_WIDTH];
            b_inj[r] = b_reg[(k*SIZE+r)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Control FSM: capture operands, run the skew counter, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      a_reg <= '0;
      b_reg <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
            t     <= '0;
            ovf   <= 1'b0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          ovf <= ovf | (|sat_vec);
          if (t == T_LAST) begin
            state <= DONE;
          end else begin
            t <= t + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      logic signed [DATA_WIDTH-1:0] a_src;
      logic signed [DATA_WIDTH-1:0] b_src;

      if (j == 0) begin : g_a_edge
        assign a_src = a_inj[i];
      end else begin : g_a_link
        assign a_src = a_fwd[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_src = b_inj[j];
      end else begin : g_b_link
        assign b_src = b_fwd[i-1][j];
      end

      systolic_mm_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (en),
        .a_in (a_src),
        .b_in (b_src),
        .a_out(a_fwd[i][j]),
        .b_out(b_fwd[i][j]),
        .acc  (result[(i*SIZE+j)*ACC_WIDTH +: ACC_WIDTH]),
        .sat  (sat_vec[i*SIZE+j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: directed and random matrix pairs against a behavioural C = A*B model.
// Latency: expects out_valid 3*SIZE-1 cycles after accept, accepts every 3*SIZE cycles streaming.
// Backpressure: stalls out_ready in DONE and checks the held result and blocked input.
module tb_systolic_mm_engine;

  localparam int DW   = 8;
  localparam int S    = 4;
  localparam int AW   = 16;
  localparam int OPW  = DW * S * S;
  localparam int RW   = AW * S * S;
  localparam int LAT  = 3 * S - 1;
  localparam int IVAL = 3 * S;

  localparam int LIT_NONE    = 0;
  localparam int LIT_IDENT   = 1;
  localparam int LIT_NEG60   = 2;
  localparam int LIT_EXTREME = 3;

  localparam longint AMAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (AW - 1));

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] a_in;
  logic [OPW-1:0] b_in;
  logic           out_valid;
  logic           out_ready;
  logic [RW-1:0]  result;
  logic           ovf;
  logic           busy;

  int lit_kind = LIT_NONE;
  bit chk_b2b  = 1'b0;

  int            checks    = 0;
  int            errors    = 0;
  int            cyc       = 0;
  bit            have      = 1'b0;
  bit            pending   = 1'b0;
  bit            prev_rst  = 1'b0;
  bit            last_b2b  = 1'b0;
  int            acc_cyc   = 0;
  int            cur_lit   = LIT_NONE;
  logic [RW-1:0] exp_res   = '0;
  logic          exp_ovf   = 1'b0;

  systolic_mm_engine #(
    .DATA_WIDTH(DW),
    .SIZE      (S),
    .ACC_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], accumulated in k order with clamp or wrap.
  function automatic void model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                output logic [RW-1:0] r, output logic o);
    longint acc;
    r = '0;
    o = 1'b0;
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        acc = 0;
        for (int k = 0; k < S; k++) begin
          acc += longint'($signed(a[(i*S+k)*DW +: DW])) * longint'($signed(b[(k*S+j)*DW +: DW]));
`ifdef SYSTOLIC_MM_SAT_EN
          if (acc > AMAX) begin
            acc = AMAX;
            o   = 1'b1;
          end else if (acc < AMIN) begin
            acc = AMIN;
            o   = 1'b1;
          end
`endif
        end
        r[(i*S+j)*AW +: AW] = AW'(acc);
      end
    end
  endfunction

  function automatic logic [OPW-1:0] mk_const(input int v);
    logic [OPW-1:0] m;
    for (int n = 0; n < S * S; n++) m[n*DW +: DW] = DW'(v);
    return m;
  endfunction

  function automatic logic [OPW-1:0] mk_ident();
    logic [OPW-1:0] m;
    for (int i = 0; i < S; i++)
      for (int k = 0; k < S; k++) m[(i*S+k)*DW +: DW] = DW'((i == k) ? 1 : 0);
    return m;
  endfunction

  function automatic logic [OPW-1:0] mk_seq();
    logic [OPW-1:0] m;
    for (int k = 0; k < S; k++)
      for (int j = 0; j < S; j++) m[(k*S+j)*DW +: DW] = DW'(k * S + j);
    return m;
  endfunction

  function automatic logic [OPW-1:0] mk_mix(input int bias);
    logic [OPW-1:0] m;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) m[(r*S+c)*DW +: DW] = DW'((r - c) * bias + r * c - 7);
    return m;
  endfunction

  function automatic logic [OPW-1:0] mk_rand();
    logic [OPW-1:0] m;
    for (int n = 0; n < S * S; n++) m[n*DW +: DW] = DW'($urandom);
    return m;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Single compare process: every cycle, outputs against the model and handshake rules.
  always @(negedge clk) begin
    cyc++;
    if (prev_rst) begin
      chk("reset_in_ready", longint'(in_ready), 1);
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_busy", longint'(busy), 0);
      chk("reset_ovf", longint'(ovf), 0);
      chk_vec("reset_result", result, '0);
      have    = 1'b0;
      pending = 1'b0;
    end else begin
      chk("in_ready_vs_txn", longint'(in_ready), longint'(!have));
      chk("busy_vs_txn", longint'(busy), longint'(have));
      if (out_valid) begin
        if (!have) begin
          chk("out_valid_without_txn", longint'(out_valid), 0);
        end else begin
          if (pending) begin
            chk("latency", longint'(cyc - acc_cyc), LAT);
            pending = 1'b0;
            case (cur_lit)
              LIT_IDENT: begin
                for (int i = 0; i < S; i++)
                  for (int j = 0; j < S; j++)
                    chk("identity_elem", longint'($signed(result[(i*S+j)*AW +: AW])), i * 4 + j);
              end
              LIT_NEG60: begin
                for (int n = 0; n < S * S; n++)
                  chk("neg60_elem", longint'($signed(result[n*AW +: AW])), -60);
                chk("neg60_ovf", longint'(ovf), 0);
              end
              LIT_EXTREME: begin
                for (int n = 0; n < S * S; n++)
`ifdef SYSTOLIC_MM_SAT_EN
                  chk("extreme_elem", longint'($signed(result[n*AW +: AW])), 32767);
                chk("extreme_ovf", longint'(ovf), 1);
`else
                  chk("extreme_elem", longint'($signed(result[n*AW +: AW])), 0);
                chk("extreme_ovf", longint'(ovf), 0);
`endif
              end
              default: ;
            endcase
          end
          chk_vec("result", result, exp_res);
          chk("ovf", longint'(ovf), longint'(exp_ovf));
          if (out_ready) have = 1'b0;
        end
      end else if (pending && (cyc - acc_cyc) >= LAT) begin
        chk("out_valid_timeout", longint'(out_valid), 1);
        pending = 1'b0;
        have    = 1'b0;
      end
    end
    if (!rst && in_valid && in_ready) begin
      if (chk_b2b && last_b2b) chk("accept_interval", longint'(cyc - acc_cyc), IVAL);
      model(a_in, b_in, exp_res, exp_ovf);
      have     = 1'b1;
      pending  = 1'b1;
      acc_cyc  = cyc;
      cur_lit  = lit_kind;
      last_b2b = chk_b2b;
    end
    prev_rst = rst;
  end

  // Present a pair until accepted (bounded), then drop in_valid after the accept edge.
  task automatic put(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input int lit);
    a_in     = a;
    b_in     = b;
    lit_kind = lit;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready && !rst) break;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic run(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input int lit);
    put(a, b, lit);
    wait_valid();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run(mk_ident(), mk_seq(), LIT_IDENT);
    run(mk_const(-3), mk_const(5), LIT_NEG60);
    run(mk_const(-128), mk_const(-128), LIT_EXTREME);
    run(mk_mix(3), mk_mix(-2), LIT_NONE);
    run(mk_const(127), mk_const(-128), LIT_NONE);

    // Backpressure: hold the result, offer a second pair while DONE, release later.
    out_ready = 1'b0;
    put(mk_mix(5), mk_seq(), LIT_NONE);
    wait_valid();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        a_in     = mk_mix(-4);
        b_in     = mk_mix(2);
        lit_kind = LIT_NONE;
        in_valid = 1'b1;
      end
    end
    out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_valid && in_ready) break;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid();
    @(posedge clk);
    #1;

    // Reset in the middle of COMPUTE (t = 5), then a clean transaction.
    put(mk_rand(), mk_rand(), LIT_NONE);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(mk_seq(), mk_ident(), LIT_NONE);

    // Back-to-back random pairs with out_ready held high.
    chk_b2b  = 1'b1;
    in_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      a_in = mk_rand();
      b_in = mk_rand();
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (in_ready) break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk_b2b  = 1'b0;
    wait_valid();
    @(posedge clk);
    #1;

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
